// File: rtl/song_menu_ctrl_pkg.sv
// Shared definitions for the song-select menu controller and the overlay
// pixel generator that draws the menu rows.
package song_menu_ctrl_pkg;

  // Menu flow: browse rows, wait for the game core to accept, then play.
  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_REQ  = 2'd1,
    ST_PLAY = 2'd2
  } menu_state_e;

  // Number of selectable song rows shown by the overlay.
  localparam int SONG_NUM_DEF = 4;

  // Width of a down-counter that must hold values 0..n-1; never narrower
  // than one bit so degenerate parameter values still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/menu_blink_timer.sv
// Highlight blink divider: counts enabled cycles and flags the cycle on
// which the highlight must flip, once every DIV enabled cycles.
module menu_blink_timer
  import song_menu_ctrl_pkg::*;
#(
  parameter int DIV = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_toggle
);

  localparam int                 CNT_W    = cnt_width(DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == CNT_LAST);

  // A clear in the same cycle restarts the half-period, so it masks the flag.
  assign o_toggle = i_enable & ~i_clear & w_at_last;

  // Half-period counter: restart on clear, count 0..DIV-1 while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/song_menu_ctrl.sv
// Song-select menu controller: moves a cursor over SONG_NUM rows, blinks
// the highlighted row, hands the chosen song to the game core through a
// start_req/start_ack handshake and returns to the menu when the game ends.
module song_menu_ctrl
  import song_menu_ctrl_pkg::*;
#(
  parameter int SONG_NUM  = SONG_NUM_DEF,
  parameter int BLINK_DIV = 12500000,
  parameter int HOLDOFF   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_back,
  input  logic       start_ack,
  input  logic       game_done,
  output logic [1:0] cursor,
  output logic [1:0] sel_song,
  output logic       highlight,
  output logic       start_req,
  output logic       menu_active
);

  localparam int                HOLD_W    = cnt_width(HOLDOFF);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);
  localparam logic [1:0]        LAST_ROW  = 2'(SONG_NUM - 1);

  menu_state_e       r_state;
  menu_state_e       w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [1:0]        r_cursor;
  logic [1:0]        r_sel_song;
  logic              r_highlight;
  logic              r_start_req;
  logic              r_menu_active;
  logic              w_highlight_nxt;
  logic              w_start_req_nxt;
  logic              w_menu_active_nxt;
  logic              w_in_menu;
  logic              w_hold_zero;
  logic              w_ok_acc;
  logic              w_up_acc;
  logic              w_dn_acc;
  logic              w_press;
  logic              w_enter_menu;
  logic              w_blink_clr;
  logic              w_blink_tog;

  // Press qualification: only in MENU, only once the holdoff has expired.
  // OK wins over a simultaneous move; up+down together cancel out and are
  // not a press at all, so they leave the holdoff untouched.
  assign w_in_menu   = (r_state == ST_MENU);
  assign w_hold_zero = (r_hold == '0);
  assign w_ok_acc    = w_in_menu & w_hold_zero & btn_ok;
  assign w_up_acc    = w_in_menu & w_hold_zero & ~btn_ok & btn_up & ~btn_down;
  assign w_dn_acc    = w_in_menu & w_hold_zero & ~btn_ok & btn_down & ~btn_up;
  assign w_press     = w_ok_acc | w_up_acc | w_dn_acc;

  // Any cursor move or return to the menu restarts the blink phase lit.
  assign w_enter_menu = (r_state != ST_MENU) && (w_state_nxt == ST_MENU);
  assign w_blink_clr  = w_enter_menu | w_up_acc | w_dn_acc;

  menu_blink_timer #(
    .DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_blink_clr),
    .i_enable (w_in_menu),
    .o_toggle (w_blink_tog)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MENU;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; start_ack outranks a same-cycle btn_back in REQ.
  always_comb begin
    // NOTE: defaulting every combinational output first means no path
    // leaves it unassigned, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_MENU: if (w_ok_acc) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (start_ack)     w_state_nxt = ST_PLAY;
        else if (btn_back) w_state_nxt = ST_MENU;
      end
      ST_PLAY: if (game_done) w_state_nxt = ST_MENU;
      default: w_state_nxt = ST_MENU;
    endcase
  end

  // FSM outputs, computed for the upcoming state so they can be registered.
  always_comb begin
    w_highlight_nxt   = r_highlight;
    w_start_req_nxt   = 1'b0;
    w_menu_active_nxt = 1'b1;
    unique case (w_state_nxt)
      ST_MENU: begin
        if (w_blink_clr)      w_highlight_nxt = 1'b1;
        else if (w_blink_tog) w_highlight_nxt = ~r_highlight;
      end
      ST_REQ: begin
        w_highlight_nxt = 1'b1;
        w_start_req_nxt = 1'b1;
      end
      ST_PLAY: begin
        w_highlight_nxt   = 1'b0;
        w_menu_active_nxt = 1'b0;
      end
      default: w_highlight_nxt = 1'b1;
    endcase
  end

  // Registered FSM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_highlight   <= 1'b1;
      r_start_req   <= 1'b0;
      r_menu_active <= 1'b1;
    end else begin
      r_highlight   <= w_highlight_nxt;
      r_start_req   <= w_start_req_nxt;
      r_menu_active <= w_menu_active_nxt;
    end
  end

  // Press holdoff: reload on an accepted press, otherwise run down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_press) begin
      r_hold <= HOLD_LOAD;
    end else if (!w_hold_zero) begin
      r_hold <= r_hold - HOLD_W'(1);
    end
  end

  // Cursor with wrap-around at both ends, and the song latched on OK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor   <= 2'd0;
      r_sel_song <= 2'd0;
    end else begin
      if (w_up_acc) begin
        r_cursor <= (r_cursor == 2'd0) ? LAST_ROW : r_cursor - 2'd1;
      end else if (w_dn_acc) begin
        r_cursor <= (r_cursor == LAST_ROW) ? 2'd0 : r_cursor + 2'd1;
      end
      if (w_ok_acc) begin
        r_sel_song <= r_cursor;
      end
    end
  end

  assign cursor      = r_cursor;
  assign sel_song    = r_sel_song;
  assign highlight   = r_highlight;
  assign start_req   = r_start_req;
  assign menu_active = r_menu_active;

endmodule

// File: tb/tb_song_menu_ctrl.sv
// Bench for song_menu_ctrl: directed menu scenarios followed by random
// button/handshake traffic, all compared against a behavioural model.
module tb_song_menu_ctrl;

  localparam int SN = 4;
  localparam int BD = 8;
  localparam int HO = 4;

  localparam int M_MENU = 0;
  localparam int M_REQ  = 1;
  localparam int M_PLAY = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_ok = 1'b0;
  logic       btn_back = 1'b0;
  logic       start_ack = 1'b0;
  logic       game_done = 1'b0;
  logic [1:0] cursor;
  logic [1:0] sel_song;
  logic       highlight;
  logic       start_req;
  logic       menu_active;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: menu phase, cursor, latched song, holdoff remaining and
  // number of MENU cycles since the blink phase last restarted.
  int m_st, m_cur, m_sel, m_hold, m_since;

  song_menu_ctrl #(
    .SONG_NUM  (SN),
    .BLINK_DIV (BD),
    .HOLDOFF   (HO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_ok      (btn_ok),
    .btn_back    (btn_back),
    .start_ack   (start_ack),
    .game_done   (game_done),
    .cursor      (cursor),
    .sel_song    (sel_song),
    .highlight   (highlight),
    .start_req   (start_req),
    .menu_active (menu_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_MENU; m_cur = 0; m_sel = 0; m_hold = 0; m_since = 0;
  endtask

  // One clock edge of the menu rules, applied to the inputs of that cycle.
  task automatic model_step(input bit u, input bit d, input bit o,
                            input bit b, input bit a, input bit g);
    bit pressed = 1'b0;
    bit moved   = 1'b0;
    int nst     = m_st;
    case (m_st)
      M_MENU: begin
        if (m_hold == 0) begin
          if (o) begin
            m_sel = m_cur; nst = M_REQ; pressed = 1'b1;
          end else if (u && !d) begin
            m_cur = (m_cur + SN - 1) % SN; pressed = 1'b1; moved = 1'b1;
          end else if (d && !u) begin
            m_cur = (m_cur + 1) % SN; pressed = 1'b1; moved = 1'b1;
          end
        end
      end
      M_REQ: begin
        if (a)      nst = M_PLAY;
        else if (b) nst = M_MENU;
      end
      default: if (g) nst = M_MENU;
    endcase
    if (pressed)         m_hold = HO - 1;
    else if (m_hold > 0) m_hold--;
    if (nst == M_MENU) begin
      if (m_st != M_MENU || moved) m_since = 0;
      else                         m_since++;
    end
    m_st = nst;
  endtask

  function automatic bit exp_highlight();
    if (m_st == M_REQ)  return 1'b1;
    if (m_st == M_PLAY) return 1'b0;
    return ((m_since / BD) % 2) == 0;
  endfunction

  task automatic check_all();
    check("cursor",      cursor,      m_cur);
    check("sel_song",    sel_song,    m_sel);
    check("highlight",   highlight,   exp_highlight());
    check("start_req",   start_req,   m_st == M_REQ);
    check("menu_active", menu_active, m_st != M_PLAY);
  endtask

  // Called at a falling edge: drive one cycle of inputs, clock, compare.
  task automatic step(input bit u, input bit d, input bit o,
                      input bit b, input bit a, input bit g);
    btn_up = u; btn_down = d; btn_ok = o; btn_back = b; start_ack = a; game_done = g;
    @(posedge clk);
    model_step(u, d, o, b, a, g);
    #1;
    check_all();
    btn_up = 0; btn_down = 0; btn_ok = 0; btn_back = 0; start_ack = 0; game_done = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must settle before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_cursor",      cursor,      2'd0);
    check("rst_sel_song",    sel_song,    2'd0);
    check("rst_highlight",   highlight,   1'b1);
    check("rst_start_req",   start_req,   1'b0);
    check("rst_menu_active", menu_active, 1'b1);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq[4];
    exp_seq = '{1, 2, 3, 0};
    model_reset();
    @(negedge clk);
    do_reset();

    // Four spaced down presses walk the cursor and wrap to 0.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 0);
      check("down_walk", cursor, exp_seq[i]);
      idle(4);
    end

    // Up at row 0 wraps to the last row; a second up inside holdoff is dropped.
    step(1, 0, 0, 0, 0, 0);
    check("up_wrap", cursor, 2'd3);
    idle(1);
    step(1, 0, 0, 0, 0, 0);
    check("up_holdoff", cursor, 2'd3);
    idle(4);

    // Select row 2, hold the request, then the game core accepts.
    step(1, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 0, 1, 0, 0, 0);
    check("ok_sel", sel_song, 2'd2);
    check("ok_req", start_req, 1'b1);
    idle(9);
    check("req_held", start_req, 1'b1);
    step(0, 0, 0, 0, 1, 0);
    check("ack_req", start_req, 1'b0);
    check("ack_menu", menu_active, 1'b0);
    step(0, 0, 0, 0, 0, 1);
    check("done_menu", menu_active, 1'b1);
    check("done_cursor", cursor, 2'd2);

    // Idle blink: toggles after 8, 16 and 24 MENU cycles.
    for (int i = 1; i <= 24; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (i == 7)  check("blink7",  highlight, 1'b1);
      if (i == 8)  check("blink8",  highlight, 1'b0);
      if (i == 16) check("blink16", highlight, 1'b1);
      if (i == 24) check("blink24", highlight, 1'b0);
    end

    // Back and ack together: ack wins.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    check("back_ack_play", menu_active, 1'b0);
    check("back_ack_req", start_req, 1'b0);
    step(0, 0, 0, 0, 0, 1);
    idle(4);
    // Back alone, right after OK (holdoff does not gate back).
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("back_menu", menu_active, 1'b1);
    check("back_req", start_req, 1'b0);
    check("back_hl", highlight, 1'b1);
    idle(4);

    // Up and down together: no move and no holdoff, so down is taken next.
    step(1, 1, 0, 0, 0, 0);
    check("updown_cursor", cursor, 2'd2);
    step(0, 1, 0, 0, 0, 0);
    check("updown_nohold", cursor, 2'd3);
    idle(4);

    // Reset in the middle of a pending request.
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("post_rst_req", start_req, 1'b0);
    end

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(9) == 0,
             $urandom_range(7) == 0, $urandom_range(11) == 0, $urandom_range(11) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/song_menu_ctrl.md
SONG_MENU_CTRL -- requirements
Module: song_menu_ctrl

Interface
REQ-001 Parameter SONG_NUM, default 4: number of selectable song rows; cursor range 0..SONG_NUM-1.
REQ-002 Parameter BLINK_DIV, default 12500000: cycles per highlight half-period (0.5 s at 25 MHz).
REQ-003 Parameter HOLDOFF, default 2500000: cycles during which new button pulses are ignored after an accepted press.
REQ-004 Port clk  input  1  pixel-domain clock; the only clock.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port btn_up  input  1  single-cycle pulse, already synchronized and debounced; move cursor up.
REQ-007 Port btn_down  input  1  single-cycle pulse; move cursor down.
REQ-008 Port btn_ok  input  1  single-cycle pulse; confirm selection.
REQ-009 Port btn_back  input  1  single-cycle pulse; cancel a pending start.
REQ-010 Port start_ack  input  1  game core accepts start request.
REQ-011 Port game_done  input  1  single-cycle pulse; game core finished or player died.
REQ-012 Port cursor  output  2  highlighted row index, drives the song-name overlay.
REQ-013 Port sel_song  output  2  latched song index for the game core.
REQ-014 Port highlight  output  1  overlay shows the cursor row highlighted when 1.
REQ-015 Port start_req  output  1  request to start sel_song; held until acknowledged.
REQ-016 Port menu_active  output  1  overlay enable; 1 in MENU and REQ.

Function
REQ-017 FSM states SHALL be MENU, REQ, PLAY; all outputs registered.
REQ-018 In MENU, an accepted btn_up SHALL set cursor to cursor-1, wrapping 0 -> SONG_NUM-1.
REQ-019 In MENU, an accepted btn_down SHALL set cursor to cursor+1, wrapping SONG_NUM-1 -> 0.
REQ-020 btn_up and btn_down asserted in the same cycle SHALL leave cursor unchanged and SHALL NOT start holdoff.
REQ-021 In MENU, accepted btn_ok SHALL latch sel_song=cursor and enter REQ next cycle; btn_ok takes priority over a simultaneous up/down.
REQ-022 A press is accepted only when the holdoff counter is 0; each accepted press loads it with HOLDOFF-1, decrementing to 0 each cycle.
REQ-023 In REQ, start_req SHALL be 1; start_ack SHALL move to PLAY and drop start_req the next cycle.
REQ-024 In REQ, btn_back (holdoff not applied) SHALL return to MENU with start_req=0; start_ack in the same cycle wins (go to PLAY).
REQ-025 In PLAY, menu_active=0, highlight=0, button pulses ignored; game_done SHALL return to MENU with cursor unchanged.
REQ-026 game_done outside PLAY and start_ack outside REQ SHALL be ignored.
REQ-027 In MENU, highlight SHALL toggle every BLINK_DIV cycles; in REQ highlight SHALL be held 1.
REQ-028 Any cursor change or entry into MENU SHALL clear the blink counter and set highlight=1 on the next cycle.
REQ-029 Counter widths SHALL be $clog2 of their parameter; no wrap beyond parameter value.

Reset
REQ-030 rst_n low SHALL asynchronously force state=MENU, cursor=0, sel_song=0, highlight=1, start_req=0, menu_active=1, blink and holdoff counters=0.
REQ-031 Reset during REQ or PLAY SHALL abandon the request/game with no extra start_req pulse after release.

Structure
REQ-032 A shared package SHALL hold the state enum (MENU/REQ/PLAY) and SONG_NUM default, shared with the overlay pixel generator.
REQ-033 The blink divider SHALL be a sub-module menu_blink_timer (inputs clear, enable; output toggle flag).

Verification (BLINK_DIV=8, HOLDOFF=4)
REQ-034 Reset, then 4 btn_down pulses spaced 5 cycles -> cursor 1,2,3,0.
REQ-035 btn_up at cursor=0, then btn_up 2 cycles later -> cursor=3 only (second pulse ignored by holdoff).
REQ-036 cursor=2, btn_ok -> sel_song=2, start_req=1 held; start_ack after 10 cycles -> start_req=0, menu_active=0 next cycle.
REQ-037 In REQ, btn_back and start_ack same cycle -> PLAY; separate run with btn_back only -> MENU, start_req=0, highlight=1.
REQ-038 Idle in MENU 24 cycles -> highlight toggles at cycles 8, 16, 24; game_done in PLAY -> MENU with previous cursor.
REQ-039 rst_n low mid-REQ -> all outputs at reset values within same cycle, no start_req after release.
